// File: rtl/ifid_hazard_ctrl.sv
// IF/ID and PC sequencing: load-use stall, branch/jump flush, ID/EX bubble
// and a saturating count of cycles in which the PC was held.
module ifid_hazard_ctrl #(
    parameter int LOAD_STALL   = 1,
    parameter int BRANCH_FLUSH = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ifid_opcode,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             hazardflag,
    output logic             idex_bubble,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counters are preloaded with length-2: the entry cycle is spent in RUN.
    localparam logic [2:0] STALL_INIT = (LOAD_STALL > 1)   ? 3'(LOAD_STALL - 2)   : 3'd0;
    localparam logic [2:0] FLUSH_INIT = (BRANCH_FLUSH > 1) ? 3'(BRANCH_FLUSH - 2) : 3'd0;

    state_t     state;
    logic [2:0] cnt;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rt_src;
    logic       lu;
    logic       br;
    logic       unused_bits;

    assign op          = ifid_opcode[31:26];
    assign rs          = ifid_opcode[25:21];
    assign rt          = ifid_opcode[20:16];
    assign unused_bits = ^ifid_opcode[15:0];

    // Only R-type, beq, bne and sw read rt; everything else writes or ignores it.
    always_comb begin
        rt_src = 1'b0;
        case (op)
            6'b000000, 6'b000100, 6'b000101, 6'b101011: rt_src = 1'b1;
            default:                                    rt_src = 1'b0;
        endcase
    end

    assign lu = idex_memread && (idex_rt != 5'd0) &&
                ((idex_rt == rs) || (rt_src && (idex_rt == rt)));
    assign br = branch_taken | jump;

    assign ctrl_state = state;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        hazardflag  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            hazardflag  = 1'b1;
            idex_bubble = 1'b1;
        end else if (br || (state == FLUSH)) begin
            hazardflag  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu || (state == STALL)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // A taken branch/jump wins in every state and (re)starts the flush window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else if (br) begin
            if (BRANCH_FLUSH > 1) begin
                state <= FLUSH;
                cnt   <= FLUSH_INIT;
            end else begin
                state <= RUN;
                cnt   <= 3'd0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (lu && (LOAD_STALL > 1)) begin
                        state <= STALL;
                        cnt   <= STALL_INIT;
                    end
                end
                STALL, FLUSH: begin
                    if (cnt == 3'd0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed bench for ifid_hazard_ctrl: default build, a LOAD_STALL=3/CNT_W=4
// build and a BRANCH_FLUSH=2 build driven side by side.
module tb_ifid_hazard_ctrl;
    logic        clk;
    logic        rst_n;
    logic [31:0] ifid_opcode;
    logic [4:0]  idex_rt;
    logic        branch_taken;
    logic        jump;
    logic        memread_a;
    logic        memread_l;
    logic        memread_f;
    logic [31:0] fetch;
    logic [31:0] ifid_q;

    logic        a_pc_write, a_ifid_write, a_hazardflag, a_idex_bubble;
    logic [1:0]  a_ctrl_state;
    logic [15:0] a_stall_cycles;
    logic        l_pc_write, l_ifid_write, l_hazardflag, l_idex_bubble;
    logic [1:0]  l_ctrl_state;
    logic [3:0]  l_stall_cycles;
    logic        f_pc_write, f_ifid_write, f_hazardflag, f_idex_bubble;
    logic [1:0]  f_ctrl_state;
    logic [15:0] f_stall_cycles;

    int total;
    int passed;
    int fails;

    localparam logic [31:0] OP_ADD  = 32'h0044_1820;  // add  $3,$2,$4
    localparam logic [31:0] OP_ADDI = 32'h20A2_0004;  // addi $2,$5,4
    localparam logic [31:0] OP_SW   = 32'hACA2_0000;  // sw   $2,0($5)
    localparam logic [31:0] OP_ZERO = 32'h0000_0020;  // add  $0,$0,$0

    ifid_hazard_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .ifid_opcode(ifid_opcode),
        .idex_memread(memread_a), .idex_rt(idex_rt),
        .branch_taken(branch_taken), .jump(jump),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write),
        .hazardflag(a_hazardflag), .idex_bubble(a_idex_bubble),
        .ctrl_state(a_ctrl_state), .stall_cycles(a_stall_cycles)
    );

    ifid_hazard_ctrl #(.LOAD_STALL(3), .BRANCH_FLUSH(1), .CNT_W(4)) dut_l (
        .clk(clk), .rst_n(rst_n), .ifid_opcode(ifid_opcode),
        .idex_memread(memread_l), .idex_rt(idex_rt),
        .branch_taken(branch_taken), .jump(jump),
        .pc_write(l_pc_write), .ifid_write(l_ifid_write),
        .hazardflag(l_hazardflag), .idex_bubble(l_idex_bubble),
        .ctrl_state(l_ctrl_state), .stall_cycles(l_stall_cycles)
    );

    ifid_hazard_ctrl #(.LOAD_STALL(1), .BRANCH_FLUSH(2), .CNT_W(16)) dut_f (
        .clk(clk), .rst_n(rst_n), .ifid_opcode(ifid_opcode),
        .idex_memread(memread_f), .idex_rt(idex_rt),
        .branch_taken(branch_taken), .jump(jump),
        .pc_write(f_pc_write), .ifid_write(f_ifid_write),
        .hazardflag(f_hazardflag), .idex_bubble(f_idex_bubble),
        .ctrl_state(f_ctrl_state), .stall_cycles(f_stall_cycles)
    );

    // IF/ID register as the pipeline would build it around dut_a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ifid_q <= '0;
        else if (a_hazardflag) ifid_q <= '0;
        else if (a_ifid_write) ifid_q <= fetch;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        total = 0; passed = 0; fails = 0;
        rst_n = 1'b0; ifid_opcode = '0; idex_rt = '0;
        branch_taken = 1'b0; jump = 1'b0;
        memread_a = 1'b0; memread_l = 1'b0; memread_f = 1'b0;
        fetch = 32'h1234_5678;

        #2;
        check("rst_pc_write", 32'(a_pc_write), 0);
        check("rst_ifid_write", 32'(a_ifid_write), 0);
        check("rst_hazardflag", 32'(a_hazardflag), 1);
        check("rst_idex_bubble", 32'(a_idex_bubble), 1);
        check("rst_state", 32'(a_ctrl_state), 0);
        cyc();
        cyc();
        check("rst_no_count", 32'(a_stall_cycles), 0);
        rst_n = 1'b1;
        #1;
        check("rel_pc_write", 32'(a_pc_write), 1);
        check("rel_idex_bubble", 32'(a_idex_bubble), 0);

        // Load-use on rs
        @(negedge clk);
        ifid_opcode = OP_ADD; idex_rt = 5'd2; memread_a = 1'b1;
        #1;
        check("lu_pc_write", 32'(a_pc_write), 0);
        check("lu_ifid_write", 32'(a_ifid_write), 0);
        check("lu_idex_bubble", 32'(a_idex_bubble), 1);
        check("lu_hazardflag", 32'(a_hazardflag), 0);
        @(negedge clk);
        memread_a = 1'b0;
        #1;
        check("lu_count", 32'(a_stall_cycles), 1);
        check("lu_released", 32'(a_pc_write), 1);
        check("lu_state", 32'(a_ctrl_state), 0);

        // rt is a destination for addi: no hazard
        @(negedge clk);
        ifid_opcode = OP_ADDI; memread_a = 1'b1;
        #1;
        check("addi_pc_write", 32'(a_pc_write), 1);
        check("addi_ifid_write", 32'(a_ifid_write), 1);
        check("addi_idex_bubble", 32'(a_idex_bubble), 0);
        @(negedge clk);
        memread_a = 1'b0;
        #1;
        check("addi_count", 32'(a_stall_cycles), 1);

        // rt is a source for sw
        @(negedge clk);
        ifid_opcode = OP_SW; memread_a = 1'b1;
        #1;
        check("sw_pc_write", 32'(a_pc_write), 0);
        @(negedge clk);
        memread_a = 1'b0;
        #1;
        check("sw_count", 32'(a_stall_cycles), 2);

        // $zero never stalls
        @(negedge clk);
        ifid_opcode = OP_ZERO; idex_rt = 5'd0; memread_a = 1'b1;
        #1;
        check("zero_pc_write", 32'(a_pc_write), 1);
        @(negedge clk);
        memread_a = 1'b0;
        #1;
        check("zero_count", 32'(a_stall_cycles), 2);
        check("ifid_loaded", ifid_q, 32'h1234_5678);

        // Branch and load-use together: flush wins
        @(negedge clk);
        ifid_opcode = OP_ADD; idex_rt = 5'd2; memread_a = 1'b1; branch_taken = 1'b1;
        #1;
        check("br_lu_hazardflag", 32'(a_hazardflag), 1);
        check("br_lu_pc_write", 32'(a_pc_write), 1);
        check("br_lu_idex_bubble", 32'(a_idex_bubble), 1);
        @(negedge clk);
        memread_a = 1'b0; branch_taken = 1'b0;
        #1;
        check("br_ifid_zeroed", ifid_q, 32'h0);
        check("br_state", 32'(a_ctrl_state), 0);
        check("br_count", 32'(a_stall_cycles), 2);
        check("f_second_flush", 32'(f_ctrl_state), 2);
        cyc();
        check("f_back_run", 32'(f_ctrl_state), 0);

        // BRANCH_FLUSH=2, jump again inside the FLUSH cycle
        @(negedge clk);
        jump = 1'b1;
        #1;
        check("j0_hazardflag", 32'(f_hazardflag), 1);
        check("j0_state", 32'(f_ctrl_state), 0);
        @(negedge clk);
        #1;
        check("j1_hazardflag", 32'(f_hazardflag), 1);
        check("j1_state", 32'(f_ctrl_state), 2);
        @(negedge clk);
        jump = 1'b0;
        #1;
        check("j2_hazardflag", 32'(f_hazardflag), 1);
        check("j2_state", 32'(f_ctrl_state), 2);
        check("j2_a_hazardflag", 32'(a_hazardflag), 0);
        cyc();
        check("j3_hazardflag", 32'(f_hazardflag), 0);
        check("j3_state", 32'(f_ctrl_state), 0);

        // LOAD_STALL=3: three held cycles, states 0,1,1,0
        @(negedge clk);
        ifid_opcode = OP_ADD; idex_rt = 5'd2; memread_l = 1'b1;
        #1;
        check("ls0_pc_write", 32'(l_pc_write), 0);
        check("ls0_state", 32'(l_ctrl_state), 0);
        @(negedge clk);
        memread_l = 1'b0;
        #1;
        check("ls1_pc_write", 32'(l_pc_write), 0);
        check("ls1_state", 32'(l_ctrl_state), 1);
        cyc();
        check("ls2_pc_write", 32'(l_pc_write), 0);
        check("ls2_state", 32'(l_ctrl_state), 1);
        cyc();
        check("ls3_pc_write", 32'(l_pc_write), 1);
        check("ls3_state", 32'(l_ctrl_state), 0);
        check("ls3_count", 32'(l_stall_cycles), 3);

        // Saturation of the 4-bit counter under a held hazard
        @(negedge clk);
        memread_l = 1'b1;
        for (int i = 0; i < 16; i++) cyc();
        check("sat_count", 32'(l_stall_cycles), 32'hF);
        check("sat_pc_write", 32'(l_pc_write), 0);
        cyc();
        check("sat_hold", 32'(l_stall_cycles), 32'hF);
        memread_l = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (l_ctrl_state == 2'd0) break;
        end
        check("drain_state", 32'(l_ctrl_state), 0);

        // Asynchronous reset in the middle of a stall
        @(negedge clk);
        memread_l = 1'b1;
        @(negedge clk);
        memread_l = 1'b0;
        #1;
        check("pre_rst_state", 32'(l_ctrl_state), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(l_ctrl_state), 0);
        check("arst_l_count", 32'(l_stall_cycles), 0);
        check("arst_a_count", 32'(a_stall_cycles), 0);
        check("arst_hazardflag", 32'(l_hazardflag), 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_pc_write", 32'(l_pc_write), 1);
        check("post_ifid_write", 32'(l_ifid_write), 1);
        check("post_idex_bubble", 32'(l_idex_bubble), 0);
        check("post_hazardflag", 32'(l_hazardflag), 0);
        cyc();
        check("post_state", 32'(l_ctrl_state), 0);
        check("post_count", 32'(l_stall_cycles), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
